// File: rtl/peri_timer_ctrl.sv
// Bus-side control stage for peri_timer: LOAD/CTRL/STATUS/COUNT registers,
// load-pulse sequencing with optional auto-reload, and a sticky maskable expiry interrupt.
module peri_timer_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] timer_data_o,
  output logic             timer_load_o,
  input  logic [WIDTH-1:0] timer_cuenta_i,
  output logic             irq_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [1:0] A_LOAD   = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_load_val;
  logic             r_en;
  logic             r_auto;
  logic             r_ie;
  logic             r_exp;
  logic             r_load_pulse;
  logic             r_irq;

  logic             w_load_wr;
  logic             w_ctrl_wr;
  logic             w_stat_wr;
  logic             w_abort;
  logic             w_cnt_zero;
  logic [1:0]       w_fsm_nxt;
  logic             w_fsm_expire;
  logic [1:0]       w_state_nxt;
  logic             w_expire;
  logic             w_en_nxt;
  logic             w_auto_nxt;
  logic             w_ie_nxt;
  logic             w_exp_nxt;

  assign w_load_wr  = we_i & (addr_i == A_LOAD);
  assign w_ctrl_wr  = we_i & (addr_i == A_CTRL);
  assign w_stat_wr  = we_i & (addr_i == A_STATUS);
  assign w_abort    = w_ctrl_wr & ~data_i[0];
  assign w_cnt_zero = (timer_cuenta_i == {WIDTH{1'b0}});

  // Sequencer next state; GUARD never looks at the count so a stale zero cannot expire.
  always_comb begin
    w_fsm_nxt    = r_state;
    w_fsm_expire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_fsm_nxt = S_LOAD;
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_LOAD:  w_fsm_nxt = S_GUARD;
      S_GUARD: w_fsm_nxt = S_RUN;
      S_RUN: begin
        if (w_cnt_zero) begin
          w_fsm_expire = 1'b1;
          w_fsm_nxt    = r_auto ? S_LOAD : S_IDLE;
        end else begin
          w_fsm_nxt    = S_RUN;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // A bus abort overrides whatever the sequencer wanted, including a same-cycle expiry.
  assign w_state_nxt = w_abort ? S_IDLE : w_fsm_nxt;
  assign w_expire    = w_fsm_expire & ~w_abort;

  // Control/status next values: bus EN beats auto-clear, expiry set beats W1C.
  always_comb begin
    w_en_nxt   = r_en;
    w_auto_nxt = r_auto;
    w_ie_nxt   = r_ie;
    w_exp_nxt  = r_exp;
    if (w_ctrl_wr) begin
      w_en_nxt   = data_i[0];
      w_auto_nxt = data_i[1];
      w_ie_nxt   = data_i[2];
    end else if (w_expire && !r_auto) begin
      w_en_nxt   = 1'b0;
    end else begin
      w_en_nxt   = r_en;
    end
    if (w_expire) begin
      w_exp_nxt = 1'b1;
    end else if (w_stat_wr && data_i[0]) begin
      w_exp_nxt = 1'b0;
    end else begin
      w_exp_nxt = r_exp;
    end
  end

  // State and register update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_load_val   <= {WIDTH{1'b0}};
      r_en         <= 1'b0;
      r_auto       <= 1'b0;
      r_ie         <= 1'b0;
      r_exp        <= 1'b0;
      r_load_pulse <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_en         <= w_en_nxt;
      r_auto       <= w_auto_nxt;
      r_ie         <= w_ie_nxt;
      r_exp        <= w_exp_nxt;
      r_load_pulse <= (w_state_nxt == S_LOAD);
      r_irq        <= w_exp_nxt & w_ie_nxt;
      if (w_load_wr) begin
        r_load_val <= data_i;
      end else begin
        r_load_val <= r_load_val;
      end
    end
  end

  // Bus read mux.
  always_comb begin
    data_o = {WIDTH{1'b0}};
    case (addr_i)
      A_LOAD:   data_o = r_load_val;
      A_CTRL:   data_o = {{(WIDTH-3){1'b0}}, r_ie, r_auto, r_en};
      A_STATUS: data_o = {{(WIDTH-2){1'b0}}, (r_state != S_IDLE), r_exp};
      A_COUNT:  data_o = timer_cuenta_i;
      default:  data_o = {WIDTH{1'b0}};
    endcase
  end

  assign timer_data_o = r_load_val;
  assign timer_load_o = r_load_pulse;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_peri_timer_ctrl.sv
// Self-checking bench for peri_timer_ctrl with a behavioural down-counting timer model.
module tb_peri_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] timer_data_o;
  logic        timer_load_o;
  logic [31:0] cnt;
  logic        irq_o;

  peri_timer_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .timer_data_o(timer_data_o), .timer_load_o(timer_load_o),
    .timer_cuenta_i(cnt), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Timer model: load on pulse, otherwise count down and hold at zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 32'd0;
    else if (timer_load_o) cnt <= timer_data_o;
    else if (cnt != 32'd0) cnt <= cnt - 32'd1;
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cyc = -1;
  int min_iv = 1000000;
  int max_iv = 0;
  int wide = 0;
  logic prev_load = 1'b0;
  logic [31:0] last_data = 32'd0;

  // Load-pulse monitor, sampled 2ns after the rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (timer_load_o) begin
      pulses = pulses + 1;
      last_data = timer_data_o;
      if (last_cyc >= 0) begin
        if (cyc - last_cyc < min_iv) min_iv = cyc - last_cyc;
        if (cyc - last_cyc > max_iv) max_iv = cyc - last_cyc;
      end
      if (prev_load) wide = wide + 1;
      last_cyc = cyc;
    end
    prev_load = timer_load_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr_i = a;
    #1;
    v = data_o;
  endtask

  task automatic clr_mon();
    pulses = 0; last_cyc = -1; min_iv = 1000000; max_iv = 0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] rv;
  int k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, "load_rw"};
    vecs[1] = '{1'b1, 2'd1, 32'h00000006, 32'h00000006, "ctrl_auto_ie"};
    vecs[2] = '{1'b1, 2'd1, 32'hFFFFFFF6, 32'h00000006, "ctrl_upper_zero"};
    vecs[3] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h00000000, "status_w1c_idle"};
    vecs[4] = '{1'b1, 2'd3, 32'h00001234, 32'h00000000, "count_ro"};
    vecs[5] = '{1'b0, 2'd0, 32'h00000000, 32'hDEADBEEF, "load_kept"};
    vecs[6] = '{1'b1, 2'd1, 32'h00000000, 32'h00000000, "ctrl_clear"};
    vecs[7] = '{1'b1, 2'd0, 32'h00000015, 32'h00000015, "load_15"};
    vecs[8] = '{1'b0, 2'd2, 32'h00000000, 32'h00000000, "status_idle"};

    rst_n = 1'b0; we_i = 1'b0; addr_i = 2'd0; data_i = 32'd0;
    repeat (300) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], rv);
      check("reset_read", rv, 32'd0);
    end
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    check("reset_tdata", timer_data_o, 32'd0);
    repeat (5) @(negedge clk);
    check("reset_no_pulse", pulses, 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rv);
      check(vecs[i].name, rv, vecs[i].exp);
    end
    check("tbl_no_pulse", pulses, 32'd0);

    // One-shot, LOAD=0x15 with IE: expiry 24 cycles after the CTRL write edge.
    clr_mon();
    wr(2'd1, 32'h5);
    repeat (8) @(negedge clk);
    rd(2'd3, rv);
    check("count_passthru", rv, 32'h0F);
    k = 8;
    while (!irq_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("oneshot_latency", k, 32'd24);
    rd(2'd2, rv);
    check("oneshot_status", rv, 32'h1);
    rd(2'd1, rv);
    check("oneshot_ctrl", rv, 32'h4);
    repeat (10) @(negedge clk);
    check("oneshot_pulses", pulses, 32'd1);
    check("oneshot_pulse_data", last_data, 32'h15);
    wr(2'd2, 32'h1);
    check("w1c_irq", {31'd0, irq_o}, 32'd0);
    rd(2'd2, rv);
    check("w1c_status", rv, 32'h0);

    // LOAD=0, EN only: expiry in the first RUN cycle, sampled 4 edges after the write.
    wr(2'd0, 32'h0);
    clr_mon();
    wr(2'd1, 32'h1);
    k = 0;
    rd(2'd2, rv);
    while (!rv[0] && k < 20) begin
      @(negedge clk);
      k++;
      rd(2'd2, rv);
    end
    check("zero_latency", k, 32'd4);
    check("zero_irq_masked", {31'd0, irq_o}, 32'd0);
    repeat (100) @(negedge clk);
    check("zero_pulses", pulses, 32'd1);
    rd(2'd1, rv);
    check("zero_ctrl", rv, 32'h0);
    wr(2'd2, 32'h1);

    // CTRL write of EN=1 landing on the expiry edge keeps EN and restarts once.
    clr_mon();
    wr(2'd1, 32'h1);
    repeat (3) @(negedge clk);
    wr(2'd1, 32'h1);
    rd(2'd1, rv);
    check("en_priority_ctrl", rv, 32'h1);
    rd(2'd2, rv);
    check("en_priority_status", rv, 32'h1);
    repeat (20) @(negedge clk);
    check("en_priority_pulses", pulses, 32'd2);
    rd(2'd1, rv);
    check("en_priority_done", rv, 32'h0);
    wr(2'd2, 32'h1);

    // Auto-reload, LOAD=0x10: pulses every 18 cycles; abort right after the 4th pulse.
    wr(2'd0, 32'h10);
    clr_mon();
    wr(2'd1, 32'h7);
    k = 0;
    while (pulses < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("auto_pulses", pulses, 32'd4);
    check("auto_min_iv", min_iv, 32'd18);
    check("auto_max_iv", max_iv, 32'd18);
    wr(2'd1, 32'h0);
    rd(2'd2, rv);
    check("auto_abort_status", rv, 32'h1);
    check("auto_abort_irq", {31'd0, irq_o}, 32'd0);
    repeat (50) @(negedge clk);
    check("auto_abort_pulses", pulses, 32'd4);
    wr(2'd2, 32'h1);

    // Abort mid-RUN, with a LOAD rewrite and a redundant EN=1 write on the way.
    wr(2'd0, 32'h1000);
    clr_mon();
    wr(2'd1, 32'h1);
    repeat (10) @(negedge clk);
    rd(2'd2, rv);
    check("abort_running", rv, 32'h2);
    wr(2'd0, 32'h55);
    check("abort_tdata_live", timer_data_o, 32'h55);
    wr(2'd1, 32'h1);
    wr(2'd1, 32'h0);
    rd(2'd2, rv);
    check("abort_status", rv, 32'h0);
    repeat (30) @(negedge clk);
    check("abort_pulses", pulses, 32'd1);
    rd(2'd2, rv);
    check("abort_status_late", rv, 32'h0);

    // LOAD=0 auto: expiries at N+4, N+7, N+10; W1C lands on N+7 then on N+8.
    wr(2'd0, 32'h0);
    clr_mon();
    wr(2'd1, 32'h7);
    repeat (6) @(negedge clk);
    wr(2'd2, 32'h1);
    rd(2'd2, rv);
    check("w1c_vs_set", rv[0], 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd2, rv);
    check("w1c_clears", rv[0], 32'h0);
    k = 0;
    while (!timer_load_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("fast_min_iv", min_iv, 32'd3);
    check("fast_max_iv", max_iv, 32'd3);
    check("pre_reset_load", {31'd0, timer_load_o}, 32'd1);
    check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_load", {31'd0, timer_load_o}, 32'd0);
    check("async_reset_irq", {31'd0, irq_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0], rv);
      check("async_reset_read", rv, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("pulse_width", wide, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
